pre_proc_hpf: RTL and testbench
===============================

Name: pre_proc_hpf

Overview:
- Pre-processor stage 1 of the G.729 encoder: second-order IIR high-pass filter (140 Hz cutoff) with input scaling by 1/2, one sample per start pulse.
- Filtered Q15 sample feeds downstream framing. The unrounded Q31 result, `acc_out`, feeds the pre-processor Q31 selection mux.
- Multi-cycle, single-multiplier datapath.
- Filter state persists across samples until reset.

Parameters:
- B0, 1899, numerator coefficient b0 (Q12, includes /2 scaling)
- B1, -3798, numerator coefficient b1
- B2, 1899, numerator coefficient b2
- A1, 7807, denominator coefficient a1 (Q12, sign already folded)
- A2, -3733, denominator coefficient a2

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; x_in sampled this cycle
- x_in  in  16  input speech sample, signed Q15
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse; y_out/acc_out valid
- y_out  out  16  filtered sample, signed Q15, rounded
- acc_out  out  32  shifted pre-round accumulator, signed Q31

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - With reset low at a rising edge, all of the following clear to 0: busy, done, y_out, acc_out, x1, x2, y1_hi, y1_lo, y2_hi, y2_lo, accumulator.
  - FSM returns to IDLE.
  - Reset mid-operation aborts the sample: no done, no state update.
- FSM states: IDLE, MA1, MA2, MB0, MB1, MB2, SHIFT, OUT.
  - IDLE: on start, latch x0=x_in, clear acc, go to MA1, set busy.
  - MA1: acc = Mpy_32_16(y1_hi, y1_lo, A1).
  - MA2: acc = L_add(acc, Mpy_32_16(y2_hi, y2_lo, A2)).
  - MB0, MB1, MB2: acc = L_mac(acc, x0/x1/x2, B0/B1/B2) respectively.
  - SHIFT: acc = L_shl(acc, 3).
  - OUT:
    - y_out = round(acc), acc_out = acc.
    - y2 takes y1; y1 = L_Extract(acc).
    - x2 takes x1; x1 takes x0.
    - Pulse done, clear busy, return to IDLE.
- Latency: start at cycle T gives done high at cycle T+8. Next start is accepted at T+8 (in IDLE the same cycle done is high is not allowed; earliest accepted start is T+8 while state is IDLE). Throughput is 1 sample per 8 cycles.
- Start while busy is ignored. No queuing; x_in is not re-sampled.
- Arithmetic is bit-exact to the ITU basic operators:
  - L_mult(a,b) = sat32(a*b*2).
  - L_mac(L,a,b) = sat32(L + L_mult(a,b)).
  - mult(a,b) = sat16((a*b)>>15), arithmetic shift.
  - Mpy_32_16(hi,lo,n) = L_mac(L_mult(hi,n), mult(lo,n), 1).
  - L_shl(L,3) saturates to 0x7FFFFFFF / 0x80000000 on overflow.
  - round(L) = upper 16 bits of sat32(L + 0x8000).
  - L_Extract: hi = L>>>16; lo = (L - (hi<<16))>>>1.
- Saturation is applied at every step, never deferred.
- y_out and acc_out hold their value between done pulses.

Optional Feature:
- Macro: HPF_SAT_FLAG_EN.
- When defined:
  - Adds output port `sat_flag` (1 bit).
  - sat_flag is sticky: set when any L_mult, L_mac, L_add, L_shl or round in a sample saturates.
  - Visible from the done cycle onward.
  - Cleared only by reset.
- When undefined: no port and no flag logic. Datapath results are identical in both builds.

Test Plan:
- Zero input: reset, then 10 starts with x_in=0 -> every done has y_out=0, acc_out=0.
- Impulse response:
  - After reset, x_in=16384 -> y_out=7596, acc_out=0x1DAC0000 (497811456).
  - Next x_in=0 -> y_out=-714, acc_out=-46791360.
- DC rejection: 400 starts with x_in=1000 -> final |y_out| <= 2 (sum of b coefficients is 0).
- Timing: start at T -> busy high T+1..T+7, done only at T+8. A start pulse at T+3 is ignored: exactly one done, and the output equals the single-sample case.
- Reset mid-sample: start, then reset low at T+4 -> no done; outputs/state 0. Re-running the impulse test gives 7596 again.
- Saturation (HPF_SAT_FLAG_EN):
  - Alternating x_in=32767/-32768 for 20 samples -> sat_flag asserts at the first saturating sample and y_out clamps to 32767 or -32768.
  - sat_flag stays 1 until reset.

Source files
------------

// File: rtl/pre_proc_hpf.sv
// pre_proc_hpf: G.729 encoder pre-processor, stage 1.
// Second-order IIR high-pass filter (140 Hz) with the /2 input scaling folded into
// the numerator. One sample is processed per accepted start pulse on a single
// 32x16 multiplier over eight FSM states. Arithmetic is bit-exact to the ITU basic
// operators, with saturation applied at every step.
// Optional build macro HPF_SAT_FLAG_EN adds a sticky sat_flag output.
module pre_proc_hpf #(
  parameter logic signed [15:0] B0 = 16'sd1899,
  parameter logic signed [15:0] B1 = -16'sd3798,
  parameter logic signed [15:0] B2 = 16'sd1899,
  parameter logic signed [15:0] A1 = 16'sd7807,
  parameter logic signed [15:0] A2 = -16'sd3733
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] y_out,
  output logic [31:0] acc_out
`ifdef HPF_SAT_FLAG_EN
  ,
  output logic        sat_flag
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MA1   = 3'd1,
    MA2   = 3'd2,
    MB0   = 3'd3,
    MB1   = 3'd4,
    MB2   = 3'd5,
    SHIFT = 3'd6,
    OUT   = 3'd7
  } state_t;

  state_t state_r, state_s;

  logic [15:0] x0_r, x1_r, x2_r;
  logic [15:0] y1_hi_r, y1_lo_r, y2_hi_r, y2_lo_r;
  logic [31:0] acc_r;

  logic signed [31:0] op_a_s;
  logic signed [15:0] op_b_s;
  logic signed [47:0] prod_s;
  logic        corner_s;
  logic [32:0] term_s;
  logic [31:0] term_sat_s;
  logic [32:0] mac_sum_s;
  logic [31:0] mac_s;
  logic        shl_ovf_s;
  logic [31:0] shl_s;
  logic [16:0] rnd_sum_s;
  logic        rnd_ovf_s;
  logic [15:0] rnd_s;

  // Clamp a 33-bit two's-complement sum into the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic [32:0] v);
    if (v[32] != v[31]) begin
      if (v[32]) sat32 = 32'h8000_0000;
      else       sat32 = 32'h7FFF_FFFF;
    end else begin
      sat32 = v[31:0];
    end
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state sequencing: a fixed walk through the seven work states.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = MA1;
        else       state_s = IDLE;
      end
      MA1:     state_s = MA2;
      MA2:     state_s = MB0;
      MB0:     state_s = MB1;
      MB1:     state_s = MB2;
      MB2:     state_s = SHIFT;
      SHIFT:   state_s = OUT;
      OUT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Multiplier operand select. The feedback taps rebuild the DPF value {hi, lo, 0}
  // so one 32x16 product yields Mpy_32_16 exactly after dropping 16 bits.
  always_comb begin
    op_a_s   = 32'sd0;
    op_b_s   = 16'sd0;
    corner_s = 1'b0;
    case (state_r)
      MA1: begin
        op_a_s   = {y1_hi_r, y1_lo_r[14:0], 1'b0};
        op_b_s   = A1;
        corner_s = (y1_hi_r == 16'h8000) && (A1 == 16'sh8000);
      end
      MA2: begin
        op_a_s   = {y2_hi_r, y2_lo_r[14:0], 1'b0};
        op_b_s   = A2;
        corner_s = (y2_hi_r == 16'h8000) && (A2 == 16'sh8000);
      end
      MB0:     begin op_a_s = {{16{x0_r[15]}}, x0_r}; op_b_s = B0; end
      MB1:     begin op_a_s = {{16{x1_r[15]}}, x1_r}; op_b_s = B1; end
      MB2:     begin op_a_s = {{16{x2_r[15]}}, x2_r}; op_b_s = B2; end
      default: begin op_a_s = 32'sd0; op_b_s = 16'sd0; end
    endcase
  end

  assign prod_s = 48'(op_a_s) * 48'(op_b_s);

  // Product term: Mpy_32_16 for feedback taps, L_mult for feed-forward taps.
  // When hi and the coefficient are both -32768, L_mult(hi,n) saturates to
  // 0x7FFFFFFF, one below the exact product, so the term is trimmed by one.
  always_comb begin
    if ((state_r == MA1) || (state_r == MA2)) begin
      if (corner_s) term_s = {prod_s[47:16], 1'b0} - 33'd1;
      else          term_s = {prod_s[47:16], 1'b0};
    end else begin
      term_s = {prod_s[31:0], 1'b0};
    end
  end

  assign term_sat_s = sat32(term_s);
  assign mac_sum_s  = {acc_r[31], acc_r} + {term_sat_s[31], term_sat_s};
  assign mac_s      = sat32(mac_sum_s);

  assign shl_ovf_s  = (acc_r[31:28] != 4'h0) && (acc_r[31:28] != 4'hF);
  assign shl_s      = shl_ovf_s ? (acc_r[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                : {acc_r[28:0], 3'b000};

  // round(): upper half plus bit 15; only positive overflow is possible.
  assign rnd_sum_s  = {acc_r[31], acc_r[31:16]} + {16'd0, acc_r[15]};
  assign rnd_ovf_s  = (rnd_sum_s[16] != rnd_sum_s[15]);
  assign rnd_s      = rnd_ovf_s ? 16'h7FFF : rnd_sum_s[15:0];

  // Datapath and filter memory; outputs only change in the OUT state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      y_out   <= 16'd0;
      acc_out <= 32'd0;
      acc_r   <= 32'd0;
      x0_r    <= 16'd0;
      x1_r    <= 16'd0;
      x2_r    <= 16'd0;
      y1_hi_r <= 16'd0;
      y1_lo_r <= 16'd0;
      y2_hi_r <= 16'd0;
      y2_lo_r <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            x0_r  <= x_in;
            acc_r <= 32'd0;
            busy  <= 1'b1;
          end
        end
        MA1, MA2, MB0, MB1, MB2: acc_r <= mac_s;
        SHIFT: acc_r <= shl_s;
        OUT: begin
          y_out   <= rnd_s;
          acc_out <= acc_r;
          y2_hi_r <= y1_hi_r;
          y2_lo_r <= y1_lo_r;
          y1_hi_r <= acc_r[31:16];
          y1_lo_r <= {1'b0, acc_r[15:1]};
          x2_r    <= x1_r;
          x1_r    <= x0_r;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HPF_SAT_FLAG_EN
  logic term_ovf_s, mac_ovf_s, sat_pend_r;

  assign term_ovf_s = (term_s[32] != term_s[31]) || corner_s;
  assign mac_ovf_s  = (mac_sum_s[32] != mac_sum_s[31]);

  // Collect saturation events during a sample and publish them on the done cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sat_pend_r <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      case (state_r)
        MA1, MA2, MB0, MB1, MB2: sat_pend_r <= sat_pend_r | term_ovf_s | mac_ovf_s;
        SHIFT:   sat_pend_r <= sat_pend_r | shl_ovf_s;
        OUT:     sat_flag   <= sat_flag | sat_pend_r | rnd_ovf_s;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pre_proc_hpf.sv
// Testbench for pre_proc_hpf: directed vector table, hand-written timing and
// reset sequences, and an ITU-operator reference model for long sequences.
module tb_pre_proc_hpf;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x_in  = 16'd0;
  logic        busy, done;
  logic [15:0] y_out;
  logic [31:0] acc_out;
`ifdef HPF_SAT_FLAG_EN
  logic        sat_flag;
`endif

  int errors = 0;
  int checks = 0;

  pre_proc_hpf dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .x_in    (x_in),
    .busy    (busy),
    .done    (done),
    .y_out   (y_out),
    .acc_out (acc_out)
`ifdef HPF_SAT_FLAG_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state (ITU operators on longint).
  longint m_x1, m_x2, m_y1h, m_y1l, m_y2h, m_y2l;
  bit     m_sat;

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) begin
      m_sat = 1'b1;
      return 64'sd2147483647;
    end
    if (v < -64'sd2147483648) begin
      m_sat = 1'b1;
      return -64'sd2147483648;
    end
    return v;
  endfunction

  function automatic longint l_mult(input longint a, input longint b);
    return sat32(a * b * 2);
  endfunction

  function automatic longint l_mac(input longint l, input longint a, input longint b);
    return sat32(l + l_mult(a, b));
  endfunction

  function automatic longint mult16(input longint a, input longint b);
    longint p;
    p = (a * b) >>> 15;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p;
  endfunction

  function automatic longint mpy_32_16(input longint hi, input longint lo, input longint n);
    return l_mac(l_mult(hi, n), mult16(lo, n), 1);
  endfunction

  task automatic model_clear();
    m_x1 = 0; m_x2 = 0; m_y1h = 0; m_y1l = 0; m_y2h = 0; m_y2l = 0; m_sat = 1'b0;
  endtask

  task automatic model_step(input longint x, output longint y, output longint acc);
    longint a;
    a = mpy_32_16(m_y1h, m_y1l, 7807);
    a = sat32(a + mpy_32_16(m_y2h, m_y2l, -3733));
    a = l_mac(a, x, 1899);
    a = l_mac(a, m_x1, -3798);
    a = l_mac(a, m_x2, 1899);
    a = sat32(a * 8);
    y = sat32(a + 32768) >>> 16;
    m_y2h = m_y1h;
    m_y2l = m_y1l;
    m_y1h = a >>> 16;
    m_y1l = (a - (m_y1h <<< 16)) >>> 1;
    m_x2 = m_x1;
    m_x1 = x;
    acc = a;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    x_in  = 16'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  // Pulse start for one cycle with x, then wait (bounded) for done.
  // lat = cycles from the start cycle to the done cycle, 0 on timeout.
  task automatic run_sample(input logic [15:0] x, output int lat);
    @(posedge clock);
    #1;
    start = 1'b1;
    x_in  = x;
    @(posedge clock);
    #1;
    start = 1'b0;
    x_in  = 16'h5A5A;
    lat   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] x;
    longint      y;
    longint      acc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    int     dones;
    longint ey, ea;
    logic [15:0] xv;

    for (int i = 0; i < 10; i++) vecs[i] = '{x: 16'd0, y: 0, acc: 0};
    vecs[10] = '{x: 16'd16384, y: 7596, acc: 497811456};
    vecs[11] = '{x: 16'd0,     y: -714, acc: -46791360};
    vecs[12] = '{x: 16'd0,     y: -688, acc: -45067040};

    model_clear();
    reset_dut();
    @(negedge clock);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_y", longint'($signed(y_out)), 0);
    check("rst_acc", longint'($signed(acc_out)), 0);
`ifdef HPF_SAT_FLAG_EN
    check("rst_sat", longint'(sat_flag), 0);
`endif

    // Zero input followed by the impulse response.
    for (int i = 0; i < 13; i++) begin
      run_sample(vecs[i].x, lat);
      check($sformatf("vec%0d_lat", i), lat, 8);
      check($sformatf("vec%0d_y", i), longint'($signed(y_out)), vecs[i].y);
      check($sformatf("vec%0d_acc", i), longint'($signed(acc_out)), vecs[i].acc);
    end

    // Cycle-accurate timing: ignored starts at T+3 and T+11, back-to-back at T+8.
    reset_dut();
    @(posedge clock);
    #1;
    start = 1'b1;
    x_in  = 16'd16384;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clock);
      #1;
      start = (k == 3) || (k == 8) || (k == 11);
      x_in  = (k == 8) ? 16'd0 : 16'd1000;
      @(negedge clock);
      check($sformatf("tim%0d_busy", k), longint'(busy),
            longint'((k <= 7) || ((k >= 9) && (k <= 15))));
      check($sformatf("tim%0d_done", k), longint'(done), longint'((k == 8) || (k == 16)));
      if (k == 8) begin
        check("tim_y1", longint'($signed(y_out)), 7596);
        check("tim_acc1", longint'($signed(acc_out)), 497811456);
      end
      if (k >= 16) begin
        check($sformatf("tim%0d_y2", k), longint'($signed(y_out)), -714);
        check($sformatf("tim%0d_acc2", k), longint'($signed(acc_out)), -46791360);
      end
    end
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("tim_no_extra_done", dones, 0);

    // Reset in the middle of a sample aborts it and clears the filter memory.
    reset_dut();
    run_sample(16'd16384, lat);
    check("mid_pre_y", longint'($signed(y_out)), 7596);
    @(posedge clock);
    #1;
    start = 1'b1;
    x_in  = 16'd0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_busy", longint'(busy), 0);
    check("mid_done", longint'(done), 0);
    check("mid_y", longint'($signed(y_out)), 0);
    check("mid_acc", longint'($signed(acc_out)), 0);
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("mid_no_done", dones, 0);
    run_sample(16'd16384, lat);
    check("mid_rerun_lat", lat, 8);
    check("mid_rerun_y", longint'($signed(y_out)), 7596);
    check("mid_rerun_acc", longint'($signed(acc_out)), 497811456);

    // DC rejection over 400 samples, tracked against the reference model.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      run_sample(16'd1000, lat);
      model_step(1000, ey, ea);
      check($sformatf("dc%0d_y", i), longint'($signed(y_out)), ey);
      check($sformatf("dc%0d_acc", i), longint'($signed(acc_out)), ea);
    end
    check("dc_final_small",
          longint'(($signed(y_out) <= 16'sd2) && ($signed(y_out) >= -16'sd2)), 1);

    // Full-scale alternating input, tracked against the reference model.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      xv = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      run_sample(xv, lat);
      model_step(longint'($signed(xv)), ey, ea);
      check($sformatf("alt%0d_lat", i), lat, 8);
      check($sformatf("alt%0d_y", i), longint'($signed(y_out)), ey);
      check($sformatf("alt%0d_acc", i), longint'($signed(acc_out)), ea);
`ifdef HPF_SAT_FLAG_EN
      check($sformatf("alt%0d_sat", i), longint'(sat_flag), longint'(m_sat));
`endif
    end
`ifdef HPF_SAT_FLAG_EN
    reset_dut();
    @(negedge clock);
    check("sat_cleared_by_reset", longint'(sat_flag), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
